// File: rtl/sys_array_scheduler.sv
// sys_array_scheduler: round-robin arbiter sequencing one shared fetcher through load/start/wait with timeout
module sys_array_scheduler #(
  parameter int N_REQ   = 4,
  parameter int SEL_W   = $clog2(N_REQ),
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             weights_load,
  output logic             start_comp,
  input  logic             ready,
  output logic [N_REQ-1:0] done,
  output logic             err,
  output logic [CNT_W-1:0] cycles
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_SETTLE, S_WAIT, S_DONE} state_t;
  state_t state;
  logic [SEL_W-1:0] prio, pick;
  logic [SEL_W:0] idx;
  logic found;
  logic [CNT_W-1:0] cnt;
  // first requesting index at or after prio, wrapping
  always_comb begin
    pick = prio;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, prio} + (SEL_W+1)'(i);
      idx = idx >= (SEL_W+1)'(N_REQ) ? idx - (SEL_W+1)'(N_REQ) : idx;
      if (!found && req[idx[SEL_W-1:0]]) begin
        found = 1'b1;
        pick = idx[SEL_W-1:0];
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      prio <= '0;
      cnt <= '0;
      grant <= '0;
      sel <= '0;
      busy <= 1'b0;
      weights_load <= 1'b0;
      start_comp <= 1'b0;
      done <= '0;
      err <= 1'b0;
      cycles <= '0;
    end else begin
      weights_load <= 1'b0;
      start_comp <= 1'b0;
      done <= '0;
      err <= 1'b0;
      case (state)
        S_IDLE: if (found) begin
          state <= S_LOAD;
          grant <= N_REQ'(1) << pick;
          sel <= pick;
          busy <= 1'b1;
          weights_load <= 1'b1;
        end
        S_LOAD: begin
          state <= S_START;
          start_comp <= 1'b1;
        end
        S_START: begin
          state <= S_SETTLE;
          cnt <= '0;
        end
        S_SETTLE: begin
          state <= cnt == CNT_W'(SETTLE-1) ? S_WAIT : S_SETTLE;
          cnt <= cnt == CNT_W'(SETTLE-1) ? '0 : cnt + 1'b1;
        end
        S_WAIT: if (ready || cnt == CNT_W'(TIMEOUT-1)) begin
          state <= S_DONE;
          done <= grant;
          err <= !ready;
          cycles <= cnt;
        end else begin
          cnt <= cnt + 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          grant <= '0;
          busy <= 1'b0;
          prio <= sel == SEL_W'(N_REQ-1) ? '0 : sel + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sys_array_scheduler.sv
// tb_sys_array_scheduler: directed + random jobs checked cycle by cycle against a job-level timing model
module tb_sys_array_scheduler;
  localparam int N = 4, ST = 2, TO = 16, CW = 16;
  logic clk = 0, reset_n = 0, ready = 0;
  logic [N-1:0] req = '0, grant, done;
  logic [1:0] sel;
  logic busy, weights_load, start_comp, err;
  logic [CW-1:0] cycles;
  int total = 0, bad = 0, prio_m = 0, last_sel = 0;
  logic [CW-1:0] last_cycles = '0;

  sys_array_scheduler #(.N_REQ(N), .SETTLE(ST), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .grant(grant), .sel(sel), .busy(busy),
    .weights_load(weights_load), .start_comp(start_comp), .ready(ready), .done(done),
    .err(err), .cycles(cycles));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int pick_owner(input logic [N-1:0] r);
    for (int i = 0; i < N; i++)
      if (r[(prio_m + i) % N]) return (prio_m + i) % N;
    return -1;
  endfunction

  // one job: grant at t=0, WAIT from t=2+ST, done at td, idle again at td+1
  task automatic run_job(input int d, input bit stale, input int chg_t, input logic [N-1:0] chg_v);
    int own, eff, td;
    bit to;
    own = pick_owner(req);
    to = !stale && d >= TO;
    eff = stale ? 0 : (to ? TO - 1 : d);
    td = 3 + ST + eff;
    for (int t = 0; t <= td + 1; t++) begin
      @(posedge clk); #1;
      chk($sformatf("job_own%0d_t%0d", own, t),
          {grant, sel, busy, weights_load, start_comp, done, err},
          {(t <= td) ? 4'(1 << own) : 4'b0, 2'(own), t <= td, t == 0, t == 1,
           (t == td) ? 4'(1 << own) : 4'b0, t == td && to});
      if (t == 0) chk("cycles_hold", 64'(cycles), 64'(last_cycles));
      if (t == td + 1) chk($sformatf("cycles_own%0d", own), 64'(cycles), 64'(eff));
      if (t == chg_t) req = chg_v;
      ready = stale ? 1'b1 : (t < 2 + ST) ? 1'($urandom_range(0, 1)) : (t >= 2 + ST + d && t < td);
    end
    last_cycles = CW'(eff);
    last_sel = own;
    prio_m = (own + 1) % N;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle", {grant, sel, busy, weights_load, start_comp, done, err},
          {4'b0, 2'(last_sel), 3'b0, 4'b0, 1'b0});
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk("reset", {grant, sel, busy, weights_load, start_comp, done, err, cycles}, '0);
    @(negedge clk) reset_n = 1;
    idle_cycles(2);
    // round robin with all requesting
    req = 4'b1111;
    for (int j = 0; j < 5; j++) run_job(3, 0, -1, '0);
    req = '0; ready = 0;
    idle_cycles(2);
    // single requester, ready 5 cycles into WAIT
    req = 4'b0010;
    run_job(5, 0, -1, '0);
    req = '0;
    idle_cycles(1);
    // stale ready held high
    req = 4'b0001; ready = 1;
    run_job(0, 1, -1, '0);
    ready = 0;
    // ready on last WAIT cycle wins over timeout, then a real timeout, then next requester
    req = 4'b1010;
    run_job(TO - 1, 0, -1, '0);
    run_job(TO, 0, -1, '0);
    run_job(2, 0, -1, '0);
    // owner drops req and another raises during WAIT
    req = 4'b0001;
    run_job(4, 0, 2 + ST + 1, 4'b1000);
    run_job(1, 0, -1, '0);
    // random jobs
    for (int j = 0; j < 24; j++) begin
      req = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 7) == 0) begin
        ready = 1;
        run_job(0, 1, -1, '0);
      end else begin
        run_job($urandom_range(0, TO + 2), 0, $urandom_range(0, 10), 4'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 3) == 0) begin
        req = '0; ready = 0;
        idle_cycles(2);
      end
    end
    // asynchronous reset during WAIT
    req = 4'b1000; ready = 0;
    repeat (3 + ST + 3) @(posedge clk);
    #2 reset_n = 0;
    #1 chk("async_reset", {grant, sel, busy, weights_load, start_comp, done, err, cycles}, '0);
    prio_m = 0; last_sel = 0; last_cycles = '0;
    req = 4'b1100;
    @(negedge clk) reset_n = 1;
    run_job(3, 0, -1, '0);
    req = '0; ready = 0;
    idle_cycles(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sys_array_scheduler.md
# sys_array_scheduler

Round-robin scheduler that shares one `sys_array_fetcher` between up to `N_REQ` requesters. It grants the fetcher to one requester at a time and drives the fetcher's `weights_load` / `start_comp` sequence. It waits for `ready` under a timeout and then returns a one-cycle completion (or error) pulse to the granted requester. It sits directly in front of the fetcher; `sel` steers the external input/weight multiplexers and the result capture.

## Interface

Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `SEL_W`, `$clog2(N_REQ)`, width of `sel`
- `SETTLE`, 2, cycles after the `start_comp` pulse during which `ready` is ignored (≥1)
- `TIMEOUT`, 1024, max cycles in WAIT before abort (≥ SETTLE+1)
- `CNT_W`, 16, width of the wait counter (must hold TIMEOUT)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req`  in  N_REQ  per-requester job request, level, held until `done` bit
- `grant`  out  N_REQ  one-hot owner of fetcher, 0 when idle
- `sel`  out  SEL_W  index of owner (holds last owner when idle)
- `busy`  out  1  high from LOAD through DONE
- `weights_load`  out  1  one-cycle pulse to fetcher
- `start_comp`  out  1  one-cycle pulse to fetcher
- `ready`  in  1  fetcher result-valid level
- `done`  out  N_REQ  one-cycle pulse to owner at job end
- `err`  out  1  one-cycle pulse with `done` when job aborted on timeout
- `cycles`  out  CNT_W  WAIT-cycle count of last completed job, held until next job ends

## Operation

- FSM states: IDLE, LOAD, START, SETTLE, WAIT, DONE.
- IDLE: if any `req` bit is set, choose the first set bit at or after `prio` (wrapping) → LOAD. Register `grant`/`sel`. Otherwise stay in IDLE.
- LOAD: `weights_load`=1 → START.
- START: `start_comp`=1, clear counter → SETTLE.
- SETTLE: count SETTLE cycles with `ready` ignored (masks stale `ready` from previous job) → WAIT.
- WAIT: counter increments each cycle. If `ready`=1, go to DONE with err=0. Else if counter == TIMEOUT−1, go to DONE with err=1. `ready` takes precedence on the same cycle.
- DONE: `done[sel]`=1, `err` per flag, `cycles` ← counter. Set `prio` ← (sel+1) mod N_REQ, clear `grant` → IDLE.
- `req` is sampled only in IDLE. Deasserting the owner's `req` mid-job does not abort the job. New requests arriving mid-job wait.
- All outputs are registered.
- Reset (any state, asynchronous): state IDLE, `prio`=0, counter=0; all outputs 0 (`grant`, `sel`, `busy`, `weights_load`, `start_comp`, `done`, `err`, `cycles`).

## Timing

- Edge k in IDLE with `req`≠0 → `grant`, `sel`, `busy` valid and `weights_load`=1 from cycle k+1.
- `start_comp`=1 in cycle k+2. SETTLE occupies cycles k+3..k+2+SETTLE. WAIT begins at k+3+SETTLE.
- `ready` first seen high in WAIT cycle w → `done` pulse in cycle w+1. Same cycle: `busy`=1 and `grant` still set. `grant`/`busy` drop at w+2.
- Earliest re-grant: IDLE at w+2, new `weights_load` at w+3. Minimum job length is therefore 4+SETTLE+1 cycles, excluding IDLE.
- `cycles` = number of WAIT cycles before `ready` was seen (0 if `ready` was high on the first WAIT cycle). On timeout, `cycles` = TIMEOUT−1.
- `weights_load`, `start_comp`, `done` and `err` are never high for more than one consecutive cycle.

## Test plan

- Single requester: `req`=4'b0010 from cycle 2, `ready` rises 5 cycles into WAIT. Required: `grant`=0010 and `sel`=1 from cycle 3, `weights_load` cycle 3, `start_comp` cycle 4, `done`=0010 one cycle, `err`=0, `cycles`=5.
- Round-robin: `req`=4'b1111 held, each job completes. Required grant order 0001, 0010, 0100, 1000, 0001, with exactly one `done` per grant.
- Stale ready: `ready` held high throughout. Required: no `done` before SETTLE elapses, then `done` on the first WAIT+1 cycle, `cycles`=0.
- Timeout: TIMEOUT=16, `ready` never rises. Required: `done` and `err` pulse together once. `cycles`=15. Next requester is granted afterwards.
- Reset mid-job: `reset_n` low during WAIT. Required: all outputs 0 asynchronously. After release with `req`=4'b0100, requester 2 is granted, with `prio` restarted at 0.
- Mid-job request change: owner drops `req` and another raises `req` during WAIT. Required: the current job completes with its `done`, and the other requester is granted next.
